// File: rtl/gph_pkg.sv
// Shared types and helpers for the serial generate/propagate/half-sum adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gph_pkg;

  localparam int GPH_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } gph_state_t;

  // A legal triple from a generate cell satisfies p >= g and h == p & ~g
  // (x&y, x|y, x^y for some x, y).
  function automatic logic gph_consistent(input logic g, input logic p, input logic h);
    return !(g && !p) && (h == (p && !g));
  endfunction

endpackage

// File: rtl/gph_carry_cell.sv
// One ripple-carry stage fed by a (g,p,h) triple; also flags illegal triples.
// Latency: combinational.
// Backpressure: none.
// Ports: g/p/h current bit triple, c_in incoming carry; s sum bit, c_out carry out, bad illegal triple.
module gph_carry_cell
  import gph_pkg::*;
(
  input  logic g,
  input  logic p,
  input  logic h,
  input  logic c_in,
  output logic s,
  output logic c_out,
  output logic bad
);

  assign s     = h ^ c_in;
  assign c_out = g | (p & c_in);
  assign bad   = ~gph_consistent(g, p, h);

endmodule

// File: rtl/gph_serial_sum.sv
// Resolves a WIDTH-bit sum from LSB-first (g,p,h) beats, one carry stage per accepted beat.
// Latency: last beat accepted in cycle N -> out_valid in cycle N+1; WIDTH+1 cycles minimum per op.
// Backpressure: in_ready drops while a result is held; result held until out_valid & out_ready.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_first/in_cin/in_g/in_p/in_h beat stream;
//        out_valid/out_ready result handshake; sum, cout, err result fields.
module gph_serial_sum
  import gph_pkg::*;
#(
  parameter int WIDTH = GPH_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_cin,
  input  logic             in_g,
  input  logic             in_p,
  input  logic             in_h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err
);

  gph_state_t       state, state_nxt;
  logic [CNT_W-1:0] idx;
  logic             carry;
  logic             accept;
  logic             last_beat;
  logic             c_sel;
  logic             cell_s, cell_c, cell_bad;

  assign accept    = in_valid & in_ready;
  assign last_beat = (idx == CNT_W'(WIDTH - 1));
  // A first beat always starts from the supplied carry-in, also when it restarts ACCUM.
  assign c_sel     = in_first ? in_cin : carry;

  gph_carry_cell u_cell (
    .g     (in_g),
    .p     (in_p),
    .h     (in_h),
    .c_in  (c_sel),
    .s     (cell_s),
    .c_out (cell_c),
    .bad   (cell_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (accept && in_first) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = ~rst;
        // A first beat here is a restart and never completes the operation.
        if (accept && !in_first && last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Non-first beats in IDLE are consumed and dropped without touching err.
          if (accept && in_first) begin
            sum[0] <= cell_s;
            carry  <= cell_c;
            idx    <= CNT_W'(1);
            err    <= cell_bad;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (in_first) begin
              sum[0] <= cell_s;
              carry  <= cell_c;
              idx    <= CNT_W'(1);
              err    <= 1'b1;
            end else begin
              sum[idx] <= cell_s;
              carry    <= cell_c;
              err      <= err | cell_bad;
              if (last_beat) begin
                cout <= cell_c;
                idx  <= '0;
              end else begin
                idx <= idx + CNT_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gph_serial_sum.sv
module tb_gph_serial_sum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_first, in_cin, in_g, in_p, in_h;
  logic       out_valid, out_ready;
  logic [5:0] sum;
  logic       cout, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gph_serial_sum #(.WIDTH(6), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_cin    (in_cin),
    .in_g      (in_g),
    .in_p      (in_p),
    .in_h      (in_h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at a negedge, let it be taken at the posedge, return at the next negedge.
  task automatic beat(input logic first, input logic cin, input logic g, input logic p, input logic h);
    in_valid = 1'b1;
    in_first = first;
    in_cin   = cin;
    in_g     = g;
    in_p     = p;
    in_h     = h;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_bits(input logic [5:0] x, input logic [5:0] y, input logic cin,
                           input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      beat(i == 0, cin, x[i] & y[i], x[i] | y[i], x[i] ^ y[i]);
  endtask

  task automatic check_result(input string tag, input logic [5:0] s, input logic c, input logic e);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},       32'(sum),       32'(s));
    chk({tag, "_cout"},      32'(cout),      32'(c));
    chk({tag, "_err"},       32'(err),       32'(e));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drained_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_first = 0; in_cin = 0; in_g = 0; in_p = 0; in_h = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 11 + 6 = 17, back-to-back beats; result visible the cycle after beat 5.
    send_bits(6'b001011, 6'b000110, 1'b0, 0, 4);
    chk("op1_not_early", 32'(out_valid), 32'd0);
    send_bits(6'b001011, 6'b000110, 1'b0, 5, 5);
    check_result("op1", 6'b010001, 1'b0, 1'b0);

    // Hold the result for 5 cycles with a first beat offered: nothing changes, nothing accepted.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_first = 1'b1; in_g = 1; in_p = 1; in_h = 0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid",    32'(out_valid), 32'd1);
      chk("hold_sum",      32'(sum),       32'b010001);
      chk("hold_cout",     32'(cout),      32'd0);
      chk("hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; in_first = 1'b0;
    drain("op1");

    // 63 + 1 wraps to 0 with carry out.
    send_bits(6'b111111, 6'b000001, 1'b0, 0, 5);
    check_result("op2", 6'b000000, 1'b1, 1'b0);
    drain("op2");

    // Carry-in only.
    send_bits(6'b000000, 6'b000000, 1'b1, 0, 5);
    check_result("op3", 6'b000001, 1'b0, 1'b0);
    drain("op3");

    // Three beats, then a restart with 1 + 1.
    send_bits(6'b001011, 6'b000110, 1'b0, 0, 2);
    send_bits(6'b000001, 6'b000001, 1'b0, 0, 5);
    check_result("restart", 6'b000010, 1'b0, 1'b1);
    drain("restart");

    // Zero operands with an illegal g=1,p=0,h=0 at bit 2: carry 1 lands in bit 3.
    for (int i = 0; i < 6; i++) begin
      if (i == 2) beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else        beat(i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_result("illegal", 6'b001000, 1'b0, 1'b1);
    drain("illegal");

    // Clean op afterwards: 3 + 5 = 8, err cleared.
    send_bits(6'b000011, 6'b000101, 1'b0, 0, 5);
    check_result("clean", 6'b001000, 1'b0, 1'b0);
    drain("clean");

    // Reset mid-accumulation after 4 beats.
    send_bits(6'b111111, 6'b111111, 1'b0, 0, 3);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Non-first (and illegal) beat in IDLE is dropped: still idle, err untouched.
    beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drop_out_valid", 32'(out_valid), 32'd0);
    chk("drop_in_ready",  32'(in_ready),  32'd1);
    chk("drop_err",       32'(err),       32'd0);

    // 7 + 9 + 1 = 17.
    send_bits(6'b000111, 6'b001001, 1'b1, 0, 5);
    check_result("post_rst", 6'b010001, 1'b0, 1'b0);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
